// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions used by the instruction-fetch stage:
// next-PC select codes, bubble encoding, IF FSM states and the IF/ID payload.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a fetched word, or inserts a bubble
// (inst cleared, valid dropped, pc4 kept).
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    input  logic            i_hold,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_pc4,
    input  logic [XLEN-1:0] i_inst,
    output if_id_t          o_if_id
);

    if_id_t r_if_id;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_if_id <= '{pc4: '0, inst: NOP_INST, valid: 1'b0};
        end else if (!i_hold) begin
            if (i_load) begin
                r_if_id <= '{pc4: i_pc4, inst: i_inst, valid: 1'b1};
            end else begin
                r_if_id.inst  <= NOP_INST;
                r_if_id.valid <= 1'b0;
            end
        end
    end

    assign o_if_id = r_if_id;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC select, imem req/ready FSM and IF/ID register.
// Build option IF_DELAY_SLOT_EN keeps the slot after a control transfer; default squashes it.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            stall,
    input  logic [1:0]      pcsource,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] ra,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid
);

    if_state_e       r_state;
    if_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] w_addr_nxt;
    logic [XLEN-1:0] r_buf;
    logic [XLEN-1:0] w_buf_nxt;
    logic            r_req;

    logic            w_fire;
    logic            w_redirect;
    logic            w_word_avail;
    logic            w_take;
    logic            w_load;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_pc_plus4;
    if_id_t          w_if_id;

`ifdef IF_DELAY_SLOT_EN
    logic            r_pend;
    logic            w_pend_nxt;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_pc_nxt;
`endif

    assign w_fire       = r_req & imem_ready;
    assign w_redirect   = w_if_id.valid & ~stall & (pcsource != PCSRC_SEQ);
    assign w_pc_plus4   = r_pc + XLEN'(4);
    // In HOLD the fetched word sits in r_buf; in REQ it comes straight from memory.
    assign w_word_avail = ((r_state == ST_REQ) & w_fire) | (r_state == ST_HOLD);
    assign w_take       = w_word_avail & ~stall;
    assign w_word       = (r_state == ST_HOLD) ? r_buf : imem_rdata;

    always_comb begin
        w_target = w_pc_plus4;
        unique case (pcsource)
            PCSRC_BR: w_target = word_align(bpc);
            PCSRC_JR: w_target = word_align(ra);
            PCSRC_J:  w_target = word_align(jpc);
            default:  w_target = w_pc_plus4;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_buf;
        w_load      = 1'b0;
`ifdef IF_DELAY_SLOT_EN
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
`endif
        unique case (r_state)
            ST_REQ: begin
                if (w_fire && stall) begin
                    w_state_nxt = ST_HOLD;
                    w_buf_nxt   = imem_rdata;
                end else if (!w_fire && r_req && w_redirect) begin
`ifdef IF_DELAY_SLOT_EN
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_target;
`else
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_DRAIN;
`endif
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (w_fire) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase

        // A word is consumed: pick the next fetch address and decide whether it enters IF/ID.
        if (w_take) begin
`ifdef IF_DELAY_SLOT_EN
            w_load = 1'b1;
            if (r_pend) begin
                w_pc_nxt   = r_pend_pc;
                w_pend_nxt = 1'b0;
            end else if (w_redirect) begin
                w_pc_nxt = w_target;
            end else begin
                w_pc_nxt = w_pc_plus4;
            end
`else
            w_load   = ~w_redirect;
            w_pc_nxt = w_redirect ? w_target : w_pc_plus4;
`endif
        end
    end

    // The address must not move while a drained request is still unanswered.
    assign w_addr_nxt = (w_state_nxt == ST_DRAIN) ? r_addr : w_pc_nxt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_buf   <= NOP_INST;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_buf   <= w_buf_nxt;
            r_req   <= (w_state_nxt != ST_HOLD);
        end
    end

`ifdef IF_DELAY_SLOT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end
`endif

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .clrn    (clrn),
        .i_hold  (stall),
        .i_load  (w_load),
        .i_pc4   (w_pc_plus4),
        .i_inst  (w_word),
        .o_if_id (w_if_id)
    );

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign pc         = r_pc;
    assign pc4        = w_if_id.pc4;
    assign inst       = w_if_id.inst;
    assign inst_valid = w_if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scenario tasks plus a scoreboard of expected
// IF/ID deliveries; follows IF_DELAY_SLOT_EN when it is defined for the build.
module tb_if_stage;

    logic        clk;
    logic        clrn;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_stall;
    int   checks   = 0;
    int   failures = 0;

    if_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .stall      (stall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back('{pc4: a + 32'd4, inst: mem_word(a)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        pcsource = 2'b00; bpc = '0; jpc = '0; ra = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        clrn = 1'b1;
    endtask

    // Scoreboard consumer: a new instruction lands in IF/ID on every edge without stall.
    always @(posedge clk) mon_stall <= stall;
    always @(negedge clk) begin
        if (clrn === 1'b1 && mon_stall === 1'b0 && inst_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra: got pc4=%h inst=%h, required no new instruction", pc4, inst);
            end else begin
                mon_e = exp_q.pop_front();
                if (pc4 !== mon_e.pc4 || inst !== mon_e.inst) begin
                    failures++;
                    $display("FAIL sb_ifid: got pc4=%h inst=%h, required pc4=%h inst=%h",
                             pc4, inst, mon_e.pc4, mon_e.inst);
                end
            end
        end
    end

    task automatic test_reset();
        clrn = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        pcsource = 2'b00; bpc = '0; jpc = '0; ra = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL reset_pc: got %h, required %h", pc, 32'h100); end
        checks++; if (pc4 !== 32'h0) begin failures++; $display("FAIL reset_pc4: got %h, required 0", pc4); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h, required 0", inst); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", inst_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        clrn = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b, required 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL first_addr: got %h, required 100", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        imem_ready = 1'b1;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        for (int i = 0; i < 3; i++) begin
            tick();
            a = 32'h100 + 32'(4 * i);
            checks++;
            if (imem_addr !== a) begin failures++; $display("FAIL zw_addr%0d: got %h, required %h", i, imem_addr, a); end
            checks++;
            if (inst_valid !== (i != 0)) begin failures++; $display("FAIL zw_valid%0d: got %b, required %b", i, inst_valid, (i != 0)); end
        end
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL zw_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        imem_ready = 1'b1;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc4 !== 32'h104 || inst !== mem_word(32'h100)) begin
                failures++; $display("FAIL stall_hold%0d: got pc4=%h inst=%h, required pc4=104 inst=%h", i, pc4, inst, mem_word(32'h100));
            end
            checks++;
            if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req%0d: got %b, required 0", i, imem_req); end
        end
        stall = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h108) begin failures++; $display("FAIL stall_resume_addr: got %h, required 108", imem_addr); end
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_wait_states();
        int bubbles;
        do_reset();
        imem_ready = 1'b0;
        bubbles = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
                failures++; $display("FAIL wait_addr%0d: got req=%b addr=%h, required req=1 addr=100", i, imem_req, imem_addr);
            end
            if (inst_valid === 1'b0 && inst === 32'h0) bubbles++;
        end
        checks++; if (bubbles != 4) begin failures++; $display("FAIL wait_bubbles: got %0d, required 4", bubbles); end
        push_exp(32'h100);
        imem_ready = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL wait_arrive: got %b, required 1", inst_valid); end
        imem_ready = 1'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wait_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_branch();
        logic [31:0] exp_inst;
        logic        exp_valid;
        do_reset();
        imem_ready = 1'b1;
        push_exp(32'h100);
`ifdef IF_DELAY_SLOT_EN
        push_exp(32'h104);
`endif
        push_exp(32'h200);
`ifdef IF_DELAY_SLOT_EN
        push_exp(32'h204);
        exp_inst = mem_word(32'h204); exp_valid = 1'b1;
`else
        exp_inst = 32'h0; exp_valid = 1'b0;
`endif
        push_exp(32'h300);
        tick();
        tick();
        pcsource = 2'b11; jpc = 32'h200;
        tick();
        pcsource = 2'b00;
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL jump_addr: got %h, required 200", imem_addr); end
        tick();
        checks++; if (inst !== mem_word(32'h200)) begin failures++; $display("FAIL br_in_id: got %h, required %h", inst, mem_word(32'h200)); end
        pcsource = 2'b01; bpc = 32'h300;
        tick();
        pcsource = 2'b00;
        checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL br_addr: got %h, required 300", imem_addr); end
        checks++;
        if (inst !== exp_inst || inst_valid !== exp_valid) begin
            failures++; $display("FAIL br_slot: got inst=%h valid=%b, required inst=%h valid=%b", inst, inst_valid, exp_inst, exp_valid);
        end
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL br_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_jr_drain();
        logic [31:0] exp_pc;
        logic        exp_valid;
        do_reset();
        imem_ready = 1'b1;
        push_exp(32'h100);
`ifdef IF_DELAY_SLOT_EN
        push_exp(32'h104);
        exp_pc = 32'h104; exp_valid = 1'b1;
`else
        exp_pc = 32'h400; exp_valid = 1'b0;
`endif
        push_exp(32'h400);
        tick();
        tick();
        imem_ready = 1'b0; pcsource = 2'b10; ra = 32'h403;
        tick();
        pcsource = 2'b00;
        checks++;
        if (imem_addr !== 32'h104 || imem_req !== 1'b1) begin
            failures++; $display("FAIL jr_addr_stable: got req=%b addr=%h, required req=1 addr=104", imem_req, imem_addr);
        end
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL jr_pc: got %h, required %h", pc, exp_pc); end
        tick();
        checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL jr_addr_wait: got %h, required 104", imem_addr); end
        imem_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h400) begin failures++; $display("FAIL jr_new_addr: got %h, required 400", imem_addr); end
        checks++; if (inst_valid !== exp_valid) begin failures++; $display("FAIL jr_discard: got valid=%b, required %b", inst_valid, exp_valid); end
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL jr_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_ready = 1'b1;
        push_exp(32'h100);
        tick();
        tick();
        imem_ready = 1'b0;
        tick();
        #2;
        clrn = 1'b0;
        #1;
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL areset_pc: got %h, required 100", pc); end
        checks++; if (pc4 !== 32'h0) begin failures++; $display("FAIL areset_pc4: got %h, required 0", pc4); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL areset_inst: got %h, required 0", inst); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b, required 0", inst_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL areset_req: got %b, required 0", imem_req); end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        push_exp(32'h100);
        imem_ready = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            failures++; $display("FAIL areset_restart: got req=%b addr=%h, required req=1 addr=100", imem_req, imem_addr);
        end
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL areset_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_wait_states();
        test_branch();
        test_jr_drain();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
